pattern_scan_sequencer: RTL

Time-multiplexes one shared pattern-finding unit across every key 1/2-strip of a CSC chamber for one event. Steps the key index through all positions and drives the hit-window mux select. Collects the returned hit count and pattern ID for each key after the unit's pipeline latency. Reports the best qualifying CLCT (key, nhits, pattern ID) with a start/busy/done handshake to the trigger logic.

---
 rtl/pattern_scan_sequencer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pattern_scan_sequencer.sv
// pattern_scan_sequencer: shares one pattern-finding unit across all key 1/2-strips of a chamber.
// Steps key_hs through 0..MXKEY-1, tags each request through a PIPE-deep shift register,
// folds returned (nhits, pid) results into a best-CLCT register and publishes it with done.
// Optional build macro SECOND_CLCT_EN adds a ranked second-best CLCT (clct2_* outputs).

module pattern_scan_sequencer #(
    parameter int unsigned MXKEY  = 160,
    parameter int unsigned MXKEYB = 8,
    parameter int unsigned MXHITB = 3,
    parameter int unsigned MXPIDB = 4,
    parameter int unsigned PIPE   = 1
) (
    input  logic              clock,
    input  logic              global_reset_n,
    input  logic              start,
    input  logic [MXHITB-1:0] hit_thresh,
    input  logic [MXPIDB-1:0] pid_thresh,
    output logic [MXKEYB-1:0] key_hs,
    output logic              key_vld,
    input  logic [MXHITB-1:0] pat_nhits,
    input  logic [MXPIDB-1:0] pat_id,
    output logic              busy,
    output logic              done,
`ifdef SECOND_CLCT_EN
    output logic              clct2_vld,
    output logic [MXKEYB-1:0] clct2_key,
    output logic [MXHITB-1:0] clct2_nhits,
    output logic [MXPIDB-1:0] clct2_pid,
`endif
    output logic              clct_vld,
    output logic [MXKEYB-1:0] clct_key,
    output logic [MXHITB-1:0] clct_nhits,
    output logic [MXPIDB-1:0] clct_pid
);

    // Drain counter only needs to reach PIPE-1.
    localparam int unsigned CntW = (PIPE > 1) ? $clog2(PIPE) : 1;
    localparam logic [MXKEYB-1:0] KeyLast   = MXKEYB'(MXKEY - 1);
    localparam logic [CntW-1:0]   DrainLast = CntW'(PIPE - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScan  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    typedef struct packed {
        logic              vld;
        logic [MXKEYB-1:0] key;
        logic [MXHITB-1:0] nhits;
        logic [MXPIDB-1:0] pid;
    } cand_t;

    // True when candidate a displaces incumbent b: more hits, or equal hits and higher pid.
    // Full ties keep the incumbent, which is always the lower key.
    function automatic logic beats(input cand_t a, input cand_t b);
        logic win;
        win = 1'b0;
        if (!b.vld) begin
            win = 1'b1;
        end else if (a.nhits > b.nhits) begin
            win = 1'b1;
        end else if ((a.nhits == b.nhits) && (a.pid > b.pid)) begin
            win = 1'b1;
        end
        return win;
    endfunction

    state_e              state_q, state_d;
    logic [MXKEYB-1:0]   key_q, key_d;
    logic                key_vld_q, key_vld_d;
    logic [CntW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [MXHITB-1:0]   hit_thr_q, hit_thr_d;
    logic [MXPIDB-1:0]   pid_thr_q, pid_thr_d;
    logic [PIPE-1:0][MXKEYB-1:0] tag_key_q;
    logic [PIPE-1:0]             tag_vld_q;
    cand_t               best1_q, best1_d;
    cand_t               clct_q, clct_d;
    cand_t               res;
`ifdef SECOND_CLCT_EN
    cand_t               best2_q, best2_d;
    cand_t               clct2_q, clct2_d;
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (key_q == KeyLast) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_cnt_q == DrainLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Request tags follow the pattern unit's latency so each result is matched to its key.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            tag_key_q <= '0;
            tag_vld_q <= '0;
        end else begin
            tag_key_q[0] <= key_q;
            tag_vld_q[0] <= key_vld_q;
            for (int i = 1; i < int'(PIPE); i++) begin
                tag_key_q[i] <= tag_key_q[i-1];
                tag_vld_q[i] <= tag_vld_q[i-1];
            end
        end
    end

    // Returned result paired with its key; vld means it is live and passes both thresholds.
    always_comb begin
        res.key   = tag_key_q[PIPE-1];
        res.nhits = pat_nhits;
        res.pid   = pat_id;
        res.vld   = tag_vld_q[PIPE-1] && (pat_nhits >= hit_thr_q) && (pat_id >= pid_thr_q);
    end

    // Ranked best list: fold in the current result, cleared when a scan is accepted.
    always_comb begin
        best1_d = best1_q;
`ifdef SECOND_CLCT_EN
        best2_d = best2_q;
`endif
        if ((state_q == StIdle) && start) begin
            best1_d = '0;
`ifdef SECOND_CLCT_EN
            best2_d = '0;
`endif
        end else if (res.vld) begin
            if (beats(res, best1_q)) begin
                best1_d = res;
`ifdef SECOND_CLCT_EN
                best2_d = best1_q;
            end else if (beats(res, best2_q)) begin
                best2_d = res;
`endif
            end
        end
    end

    // Key sequencing, threshold latching, drain counting and result publication.
    always_comb begin
        key_d       = key_q;
        key_vld_d   = key_vld_q;
        drain_cnt_d = drain_cnt_q;
        hit_thr_d   = hit_thr_q;
        pid_thr_d   = pid_thr_q;
        clct_d      = clct_q;
`ifdef SECOND_CLCT_EN
        clct2_d     = clct2_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d     = '0;
                    key_vld_d = 1'b1;
                    hit_thr_d = hit_thresh;
                    pid_thr_d = pid_thresh;
                end
            end
            StScan: begin
                if (key_q == KeyLast) begin
                    // Hold the last key on the mux; no wrap back to 0.
                    key_vld_d   = 1'b0;
                    drain_cnt_d = '0;
                end else begin
                    key_d = key_q + MXKEYB'(1);
                end
            end
            StDrain: begin
                if (drain_cnt_q == DrainLast) begin
                    // The final result lands on this edge, so publish the folded value.
                    clct_d = best1_d;
`ifdef SECOND_CLCT_EN
                    clct2_d = best2_d;
`endif
                end else begin
                    drain_cnt_d = drain_cnt_q + CntW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            key_q       <= '0;
            key_vld_q   <= 1'b0;
            drain_cnt_q <= '0;
            hit_thr_q   <= '0;
            pid_thr_q   <= '0;
            best1_q     <= '0;
            clct_q      <= '0;
`ifdef SECOND_CLCT_EN
            best2_q     <= '0;
            clct2_q     <= '0;
`endif
        end else begin
            key_q       <= key_d;
            key_vld_q   <= key_vld_d;
            drain_cnt_q <= drain_cnt_d;
            hit_thr_q   <= hit_thr_d;
            pid_thr_q   <= pid_thr_d;
            best1_q     <= best1_d;
            clct_q      <= clct_d;
`ifdef SECOND_CLCT_EN
            best2_q     <= best2_d;
            clct2_q     <= clct2_d;
`endif
        end
    end

    // Output decode.
    always_comb begin
        key_hs     = key_q;
        key_vld    = key_vld_q;
        busy       = (state_q == StScan) || (state_q == StDrain);
        done       = (state_q == StDone);
        clct_vld   = clct_q.vld;
        clct_key   = clct_q.key;
        clct_nhits = clct_q.nhits;
        clct_pid   = clct_q.pid;
`ifdef SECOND_CLCT_EN
        clct2_vld   = clct2_q.vld;
        clct2_key   = clct2_q.key;
        clct2_nhits = clct2_q.nhits;
        clct2_pid   = clct2_q.pid;
`endif
    end

endmodule
